// File: rtl/xilly_mem_bank.sv
// Seekable memory bank behind a Xillybus-style write/read stream pair.
// Shared seek address drives both pointers; reads are registered and read-first.
module xilly_mem_bank #(
  parameter int DW   = 8,
  parameter int AW   = 5,
  parameter int WRAP = 1
) (
  input  logic          bus_clk,
  input  logic          bus_rst_n,
  input  logic          user_w_mem_wren,
  input  logic [DW-1:0] user_w_mem_data,
  output logic          user_w_mem_full,
  input  logic          user_w_mem_open,
  input  logic          user_r_mem_rden,
  output logic [DW-1:0] user_r_mem_data,
  output logic          user_r_mem_empty,
  output logic          user_r_mem_eof,
  input  logic          user_r_mem_open,
  input  logic [AW-1:0] user_mem_addr,
  input  logic          user_mem_addr_update,
  output logic          user_w_mem_ovf
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] PTR_END = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    rst_q;
  logic          rst_int;
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW-1:0] waddr;
  logic          wr_stop, we, rd_go;
  logic [DW-1:0] data_q;
  logic          empty_q, eof_q, ovf_q;
  logic          unused_open;

  // Assert asynchronously, release on a clock edge so every pointer leaves reset together.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) rst_q <= '0;
    else            rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_int = rst_q[1];

  always_comb begin
    waddr      = user_mem_addr_update ? user_mem_addr : wr_ptr[AW-1:0];
    wr_stop    = (WRAP == 0) && !user_mem_addr_update && (wr_ptr == PTR_END);
    we         = user_w_mem_wren && !wr_stop;
    wr_ptr_nxt = wr_ptr;
    if (we)
      wr_ptr_nxt = (WRAP != 0) ? {1'b0, waddr + AW'(1)} : ({1'b0, waddr} + PTR_ONE);
    else if (user_mem_addr_update)
      wr_ptr_nxt = {1'b0, user_mem_addr};

    rd_go      = user_r_mem_rden && !empty_q && !user_mem_addr_update;
    rd_ptr_nxt = rd_ptr;
    if (user_mem_addr_update)
      rd_ptr_nxt = {1'b0, user_mem_addr};
    else if (rd_go)
      rd_ptr_nxt = (WRAP != 0) ? {1'b0, rd_ptr[AW-1:0] + AW'(1)} : (rd_ptr + PTR_ONE);
  end

  always_ff @(posedge bus_clk) begin
    if (we) mem[waddr] <= user_w_mem_data;
  end

  always_ff @(posedge bus_clk or negedge rst_int) begin
    if (!rst_int) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      data_q  <= '0;
      empty_q <= 1'b1;
      eof_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      if (rd_go) data_q <= mem[rd_ptr[AW-1:0]];
      // Flags are computed from the post-update pointer so they line up with it.
      empty_q <= !user_r_mem_open || user_mem_addr_update ||
                 ((WRAP == 0) && (rd_ptr_nxt == PTR_END));
      eof_q   <= (WRAP == 0) && user_r_mem_open && !user_mem_addr_update &&
                 (rd_ptr_nxt == PTR_END);
      if (user_mem_addr_update) ovf_q <= 1'b0;
      else if (wr_stop && user_w_mem_wren) ovf_q <= 1'b1;
    end
  end

  assign unused_open      = user_w_mem_open;
  assign user_w_mem_full  = 1'b0;
  assign user_r_mem_data  = data_q;
  assign user_r_mem_empty = empty_q;
  assign user_r_mem_eof   = eof_q;
  assign user_w_mem_ovf   = ovf_q;

endmodule
